arbiter_rr_4: RTL and testbench

Round-robin arbiter that drives the `sel` input of the 4:1 N-bit multiplexer `multiplex_4_1_N`. It sits directly upstream of that multiplexer: four producers raise `req` while their word is on `d0..d3`, the arbiter picks one, steers the mux, and runs a valid/ready handshake with the consumer behind the mux. Grants are bounded by a burst limit, so no producer can starve the others.

---
 rtl/arbiter_pkg.sv | 16 +
 rtl/rr_pick_4.sv | 28 ++
 rtl/arbiter_rr_4.sv | 88 ++++++++
 tb/tb_arbiter_rr_4.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared constants and state encoding for the 4-channel round-robin arbiter.
package arbiter_pkg;

    localparam int unsigned NCH  = 4;
    localparam int unsigned SELW = 2;
    localparam int unsigned CNTW = 8;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    typedef enum logic {
        S_IDLE  = ST_IDLE,
        S_GRANT = ST_GRANT
    } state_e;

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin search: first asserted request after 'start',
// wrapping modulo 4, so 'start' itself is considered last.
module rr_pick_4
    import arbiter_pkg::*;
(
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] start,
    output logic [SELW-1:0] win,
    output logic            any
);

    logic [SELW-1:0] idx;

    // Walk from the farthest offset down so the nearest hit wins.
    always_comb begin
        win = start;
        any = 1'b0;
        idx = start;
        for (int i = int'(NCH); i > 0; i--) begin
            idx = start + SELW'(i);
            if (req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbiter_rr_4.sv
// Round-robin arbiter with burst limit steering a 4:1 mux select and running
// the valid/ready handshake toward the consumer.
module arbiter_rr_4
    import arbiter_pkg::*;
#(
    parameter int unsigned BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  req,
    input  logic            ready,
    output logic [SELW-1:0] sel,
    output logic            valid,
    output logic [NCH-1:0]  ack,
    output logic            busy
);

    localparam int unsigned CW1 = CNTW + 1;

    state_e          state, state_d;
    logic [SELW-1:0] sel_d, ptr, ptr_d, start, win;
    logic [CNTW-1:0] cnt, cnt_d;
    logic            any, xfer, last_beat;

    // In GRANT ptr equals sel, so the search always starts after the last winner.
    assign start = (state == S_GRANT) ? sel : ptr;

    rr_pick_4 u_pick (
        .req   (req),
        .start (start),
        .win   (win),
        .any   (any)
    );

    always_comb begin
        busy      = (state == S_GRANT);
        valid     = busy & req[sel];
        xfer      = valid & ready;
        ack       = xfer ? (NCH'(1) << sel) : '0;
        last_beat = (CW1'(cnt) + CW1'(1)) == CW1'(BURST);
    end

    always_comb begin
        state_d = state;
        sel_d   = sel;
        ptr_d   = ptr;
        cnt_d   = cnt;
        case (state)
            S_IDLE: begin
                if (any) begin
                    state_d = S_GRANT;
                    sel_d   = win;
                    ptr_d   = win;
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (!req[sel] || (xfer && last_beat)) begin
                    cnt_d = '0;
                    if (any) begin
                        sel_d = win;
                        ptr_d = win;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (xfer) begin
                    cnt_d = cnt + CNTW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            sel   <= '0;
            ptr   <= '1;
            cnt   <= '0;
        end else begin
            state <= state_d;
            sel   <= sel_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_arbiter_rr_4.sv
// Bench for arbiter_rr_4: BURST=4 and BURST=1 instances, a mux on the
// BURST=4 instance, a transaction-level model and directed scenarios.
module tb_arbiter_rr_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0;
    logic       ready = 1'b0;

    logic [1:0] sel4, sel1;
    logic       valid4, valid1, busy4, busy1;
    logic [3:0] ack4, ack1;
    logic [2:0] word [4];
    logic [2:0] y;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arbiter_rr_4 #(.BURST(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
        .sel(sel4), .valid(valid4), .ack(ack4), .busy(busy4)
    );

    arbiter_rr_4 #(.BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready),
        .sel(sel1), .valid(valid1), .ack(ack1), .busy(busy1)
    );

    // Mux of the producers' words steered by dut4.
    assign y = word[sel4];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n)       word[i] <= 3'(2 * i);
            else if (ack4[i]) word[i] <= word[i] + 3'd1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: whether a channel holds the grant, which one, and beats left.
    bit m_act  [2];
    int m_ch   [2];
    int m_last [2];
    int m_left [2];

    function automatic int burst_of(input int u);
        return (u == 0) ? 4 : 1;
    endfunction

    function automatic int pick(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                m_act[u]  <= 1'b0;
                m_ch[u]   <= 0;
                m_last[u] <= 3;
                m_left[u] <= burst_of(u);
            end else if (!m_act[u]) begin
                if (pick(req, m_last[u]) >= 0) begin
                    m_act[u]  <= 1'b1;
                    m_ch[u]   <= pick(req, m_last[u]);
                    m_last[u] <= pick(req, m_last[u]);
                    m_left[u] <= burst_of(u);
                end
            end else if (!req[m_ch[u]] || (ready && m_left[u] == 1)) begin
                m_left[u] <= burst_of(u);
                if (pick(req, m_ch[u]) >= 0) begin
                    m_ch[u]   <= pick(req, m_ch[u]);
                    m_last[u] <= pick(req, m_ch[u]);
                end else begin
                    m_act[u]  <= 1'b0;
                    m_last[u] <= m_ch[u];
                end
            end else if (ready) begin
                m_left[u] <= m_left[u] - 1;
            end
        end
    end

    task automatic cmp_unit(input int u, input logic [1:0] s, input logic v,
                            input logic [3:0] a, input logic b);
        bit         ev;
        logic [3:0] ea;
        ev = m_act[u] && req[m_ch[u]];
        ea = (ev && ready) ? 4'(1 << m_ch[u]) : 4'b0;
        chk($sformatf("dut%0d.valid", burst_of(u)), int'(v), int'(ev));
        chk($sformatf("dut%0d.ack", burst_of(u)), int'(a), int'(ea));
        chk($sformatf("dut%0d.busy", burst_of(u)), int'(b), int'(m_act[u]));
        chk($sformatf("dut%0d.sel", burst_of(u)), int'(s), m_ch[u]);
    endtask

    always @(negedge clk) begin
        cmp_unit(0, sel4, valid4, ack4, busy4);
        cmp_unit(1, sel1, valid1, ack1, busy1);
        if (m_act[0] && req[m_ch[0]]) chk("mux.y", int'(y), int'(word[m_ch[0]]));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        req   = 4'b0;
        ready = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    int   n;
    int   seq [$];

    initial begin
        do_reset();
        settle();
        chk("rst.sel", int'(sel4), 0);
        chk("rst.valid", int'(valid4), 0);
        chk("rst.ack", int'(ack4), 0);
        chk("rst.busy", int'(busy4), 0);

        // Sole requester on channel 2: re-granted across bursts with no gap.
        req = 4'b0100; ready = 1'b1;
        settle();
        chk("s1.idle_valid", int'(valid4), 0);
        tick();
        settle();
        chk("s1.sel", int'(sel4), 2);
        chk("s1.valid", int'(valid4), 1);
        chk("s1.ack", int'(ack4), 4);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (ack4 == 4'b0100) n++;
            tick();
            settle();
        end
        chk("s1.acks", n, 8);

        // All four requesting: 0,1,2,3,0 with four beats each.
        do_reset();
        req = 4'b1111; ready = 1'b1;
        for (int i = 0; i < 21; i++) begin
            settle();
            if (ack4 != 4'b0) seq.push_back(int'(sel4));
            tick();
        end
        chk("s2.count", seq.size(), 20);
        for (int k = 0; k < 20 && k < seq.size(); k++) chk("s2.order", seq[k], (k / 4) % 4);

        // Stall on channel 1 keeps the beat count.
        do_reset();
        req = 4'b0010; ready = 1'b1;
        tick();
        tick();
        tick();
        ready = 1'b0;
        settle();
        for (int i = 0; i < 3; i++) begin
            chk("s3.stall_valid", int'(valid4), 1);
            chk("s3.stall_ack", int'(ack4), 0);
            chk("s3.stall_sel", int'(sel4), 1);
            tick();
            settle();
        end
        req = 4'b0011; ready = 1'b1;
        settle();
        chk("s3.beat3", int'(ack4), 2);
        tick();
        settle();
        chk("s3.beat4", int'(ack4), 2);
        tick();
        settle();
        chk("s3.switch_sel", int'(sel4), 0);
        chk("s3.switch_ack", int'(ack4), 1);

        // Channel 3 drops early; hand-off to 0, then back to 3, then idle.
        do_reset();
        req = 4'b1000; ready = 1'b1;
        tick();
        tick();
        tick();
        req = 4'b0001;
        settle();
        chk("s4.drop_valid", int'(valid4), 0);
        chk("s4.drop_ack", int'(ack4), 0);
        chk("s4.drop_busy", int'(busy4), 1);
        tick();
        settle();
        chk("s4.next_sel", int'(sel4), 0);
        chk("s4.next_valid", int'(valid4), 1);
        req = 4'b1000;
        settle();
        chk("s4.drop0_valid", int'(valid4), 0);
        tick();
        settle();
        chk("s4.back_sel", int'(sel4), 3);
        chk("s4.back_valid", int'(valid4), 1);
        tick();
        tick();
        req = 4'b0000;
        settle();
        chk("s4.none_valid", int'(valid4), 0);
        tick();
        settle();
        chk("s4.idle_busy", int'(busy4), 0);
        chk("s4.idle_valid", int'(valid4), 0);

        // BURST=1 alternates between channels 1 and 3.
        do_reset();
        req = 4'b1010; ready = 1'b1;
        tick();
        settle();
        for (int k = 0; k < 4; k++) begin
            chk("s5.sel", int'(sel1), (k % 2 == 0) ? 1 : 3);
            chk("s5.ack", int'(ack1), (k % 2 == 0) ? 2 : 8);
            tick();
            settle();
        end

        // Reset mid-burst, then lowest requester wins first.
        do_reset();
        req = 4'b0110; ready = 1'b1;
        tick();
        tick();
        settle();
        chk("s6.pre_valid", int'(valid4), 1);
        rst_n = 1'b0;
        #1;
        chk("s6.rst_valid", int'(valid4), 0);
        chk("s6.rst_ack", int'(ack4), 0);
        chk("s6.rst_busy", int'(busy4), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        settle();
        chk("s6.post_busy", int'(busy4), 0);
        tick();
        settle();
        chk("s6.first_sel", int'(sel4), 1);
        chk("s6.first_valid", int'(valid4), 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
